// File: rtl/e203_ifu_predec_q.sv
// rtl/e203_ifu_predec_q.sv - predecoding instruction queue with static branch prediction
//
// Purpose: buffers fetched instructions in a small FIFO. Each instruction is
// classified (jal/jalr/bxx) and statically predicted when it is pushed. The
// results are stored alongside it, so every output comes from registered storage.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_valid/i_ready            push handshake; i_instr, i_pc carry the instruction
//   flush                      drops every queued entry at the next edge
//   o_valid/o_ready            pop handshake for the head entry
//   o_instr, o_pc, o_rs1idx    head entry fields (zero when o_valid=0)
//   o_jal/o_jalr/o_bxx/o_bjp   head entry decode class
//   o_prdt_taken, o_prdt_pc    head entry static prediction
//   o_count                    number of occupied entries

module e203_ifu_predec_q #(
    parameter int DEPTH   = 2,
    parameter int PC_W    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [31:0]              i_instr,
    input  logic [PC_W-1:0]          i_pc,
    input  logic                     flush,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [31:0]              o_instr,
    output logic [PC_W-1:0]          o_pc,
    output logic [RFIDX_W-1:0]       o_rs1idx,
    output logic                     o_jal,
    output logic                     o_jalr,
    output logic                     o_bxx,
    output logic                     o_bjp,
    output logic                     o_prdt_taken,
    output logic [PC_W-1:0]          o_prdt_pc,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_W-1:0]     pc;
        logic [RFIDX_W-1:0]  rs1idx;
        logic                jal;
        logic                jalr;
        logic                bxx;
        logic                taken;
        logic [PC_W-1:0]     prdt_pc;
    } entry_t;

    // ---------------- push-side predecode ----------------
    logic            is32;
    logic [PC_W-1:0] j_imm;
    logic [PC_W-1:0] b_imm;
    entry_t          dec;

    assign is32  = (i_instr[1:0] == 2'b11);
    assign j_imm = {{(PC_W-20){i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
    assign b_imm = {{(PC_W-12){i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

    always_comb begin
        dec         = '0;
        dec.instr   = i_instr;
        dec.pc      = i_pc;
        // The full 7-bit opcode compare already implies instr[1:0]==11.
        dec.jal     = (i_instr[6:0] == 7'b1101111);
        dec.jalr    = (i_instr[6:0] == 7'b1100111);
        dec.bxx     = (i_instr[6:0] == 7'b1100011);
        dec.rs1idx  = is32 ? RFIDX_W'(i_instr[19:15]) : '0;
        // Backward conditional branches are assumed to be loops; jalr target is unknown here.
        dec.taken   = dec.jal | (dec.bxx & i_instr[31]);
        if (dec.taken) begin
            dec.prdt_pc = i_pc + (dec.jal ? j_imm : b_imm);
        end else if (is32) begin
            dec.prdt_pc = i_pc + {{(PC_W-3){1'b0}}, 3'd4};
        end else begin
            dec.prdt_pc = i_pc + {{(PC_W-2){1'b0}}, 2'd2};
        end
    end

    // ---------------- queue control ----------------
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rdy_en_q;
    logic             full, push, pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    // rdy_en_q keeps i_ready low during reset and for the first cycle after release.
    assign i_ready = rdy_en_q & ~full & ~flush;
    assign o_valid = (count_q != '0);
    assign push    = i_valid & i_ready;
    assign pop     = o_valid & o_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Entry storage carries no reset; occupancy alone decides validity.
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    // ---------------- head outputs ----------------
    entry_t head;

    assign head         = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_instr      = head.instr;
    assign o_pc         = head.pc;
    assign o_rs1idx     = head.rs1idx;
    assign o_jal        = head.jal;
    assign o_jalr       = head.jalr;
    assign o_bxx        = head.bxx;
    assign o_bjp        = head.jal | head.jalr | head.bxx;
    assign o_prdt_taken = head.taken;
    assign o_prdt_pc    = head.prdt_pc;
    assign o_count      = count_q;

endmodule

// File: doc/e203_ifu_predec_q.md
E203_IFU_PREDEC_Q -- requirements
Module: e203_ifu_predec_q

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning queue entries (power of two, 2..8).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC and prediction-target width.
REQ-003 SHALL have parameter RFIDX_W, default 5, meaning register-index width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock.
REQ-005 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-006 SHALL have port i_valid, input, 1, meaning a fetched instruction is offered.
REQ-007 SHALL have port i_ready, output, 1, meaning the queue accepts the offered instruction.
REQ-008 SHALL have port i_instr, input, 32, meaning the raw instruction.
REQ-009 SHALL have port i_pc, input, PC_W, meaning the instruction address.
REQ-010 SHALL have port flush, input, 1, meaning discard all queued entries.
REQ-011 SHALL have port o_valid, input-side complement output, 1, meaning the head entry is valid.
REQ-012 SHALL have port o_ready, input, 1, meaning the consumer takes the head entry.
REQ-013 SHALL have ports o_instr (32), o_pc (PC_W), and o_rs1idx (RFIDX_W), all outputs, meaning head-entry fields.
REQ-014 SHALL have ports o_jal, o_jalr, o_bxx, and o_bjp, outputs, 1 each, meaning the head entry's decode class.
REQ-015 SHALL have ports o_prdt_taken (1) and o_prdt_pc (PC_W), outputs, meaning static prediction.
REQ-016 SHALL have port o_count, output, $clog2(DEPTH)+1, meaning occupied entries.

Function
REQ-017 SHALL decode at push time: jal = instr[6:0]==1101111; jalr = 1100111; bxx = 1100011; all require instr[1:0]==11; bjp = jal|jalr|bxx.
REQ-018 SHALL set rs1idx = instr[19:15] for 32-bit instructions, and 0 otherwise.
REQ-019 SHALL form immediates sign-extended to PC_W: J-imm for jal, B-imm for bxx.
REQ-020 SHALL predict taken for jal, taken for bxx with negative B-imm (instr[31]=1), and not-taken otherwise, including for jalr.
REQ-021 SHALL compute o_prdt_pc, modulo 2^PC_W, as follows:
- pc + imm when predicted taken;
- otherwise pc + 4 for 32-bit instructions;
- otherwise pc + 2 (instr[1:0]!=11, all decode flags 0).
REQ-022 SHALL store the decoded fields and the prediction in the entry, so the outputs come straight from registered head storage with no combinational path from i_instr.
REQ-023 SHALL define a push as i_valid & i_ready and a pop as o_valid & o_ready; latency is one cycle, so an entry pushed in cycle N is visible on the outputs in cycle N+1 at the earliest.
REQ-024 SHALL drive i_ready = !full & !flush, and o_valid = (count!=0).
REQ-025 SHALL, on a simultaneous push and pop when not full, leave count unchanged and advance both pointers.
REQ-026 SHALL, when full, refuse a push even if a pop occurs in the same cycle.
REQ-027 SHALL wrap the read and write pointers modulo DEPTH.
REQ-028 SHALL preserve FIFO order.
REQ-029 SHALL, on flush, set count to 0 and both pointers to 0 at the next edge, ignore any push or pop in that cycle, and keep o_valid low the following cycle.
REQ-030 SHALL hold the head entry's outputs stable while o_valid=1 and o_ready=0.
REQ-031 SHALL drive all o_* data outputs to 0 when o_valid=0.

Reset
REQ-032 SHALL, on rst_n low, asynchronously clear the pointers and count.
REQ-033 SHALL, on rst_n low, asynchronously drive o_valid=0, o_count=0, and i_ready=0 while rst_n is low.
REQ-034 SHALL assert i_ready one cycle after rst_n releases.
REQ-035 SHALL need no reset on entry storage.
REQ-036 SHALL, on reset asserted mid-operation, discard all entries with no partial pop.

Verification
REQ-037 SHALL cover: push instr 0x0080006F (jal +8) at pc 0x100 -> next cycle o_jal=1, o_bjp=1, o_prdt_taken=1, o_prdt_pc=0x108.
REQ-038 SHALL cover: push 0xFE000EE3 (beq x0,x0,-4) at pc 0x200 -> o_bxx=1, o_prdt_taken=1, o_prdt_pc=0x1FC; push 0x00000463 (beq +8) at pc 0x200 -> taken=0, o_prdt_pc=0x204.
REQ-039 SHALL cover: push 0x000500E7 (jalr x1,0(x10)) -> o_jalr=1, o_rs1idx=10, taken=0; push 16-bit 0x4501 at pc 0x300 -> bjp=0, o_prdt_pc=0x302.
REQ-040 SHALL cover, with DEPTH=2 and o_ready=0: push 3 instructions -> i_ready low after 2, o_count=2; pop one -> order preserved, pointer wraps, and a 3rd push is accepted the following cycle.
REQ-041 SHALL cover: flush asserted with 2 entries plus concurrent i_valid -> next cycle o_count=0 and o_valid=0, and the concurrent instruction is not stored.
REQ-042 SHALL cover: rst_n pulsed low asynchronously mid-stream -> o_valid=0 and o_count=0 immediately, with no entries after release.
